ifu_fetch_ctrl: RTL

- Instruction-fetch sequencer that drives the read port of im_4k (4 KB, word-addressed, synchronous read).
- Owns the PC and issues im_4k reads into a small prefetch FIFO.
- Presents instructions to the decode stage with a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding stale reads; flags PCs outside the 4 KB window.

---
 rtl/ifu_fetch_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ifu_fetch_ctrl: PC sequencer feeding im_4k reads into a prefetch FIFO for decode (rev 1.0).
// Optional IFU_FETCH_PERF_EN adds perf_fetch/perf_stall/perf_flush counters.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        im_en,
  output logic [9:0]  im_addr,
  input  logic [31:0] im_dout,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_err,
  output logic [31:0] err_pc
`ifdef IFU_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [31:0]     fetch_pc;
  logic [31:0]     tag_pc;
  logic            inflight;
  logic [31:0]     data_q [BUF_DEPTH];
  logic [31:0]     pc_q   [BUF_DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;

  logic [31:0]     pc_off;
  logic            pc_ok;
  logic            pop_now;
  logic            push;
  logic [CW:0]     occupancy;
  logic            room;
  logic            would_issue;
  logic            err_trip;
  logic            unused_bits;

  assign pc_off      = fetch_pc - RESET_PC;
  assign im_addr     = pc_off[11:2];
  assign unused_bits = ^pc_off[1:0];
  assign pc_ok       = (fetch_pc[1:0] == 2'b00) && (pc_off[31:12] == 20'd0);

  assign instr_valid = (count != '0);
  assign instr       = data_q[rd_ptr];
  assign instr_pc    = pc_q[rd_ptr];
  assign pop_now     = instr_valid && instr_ready;
  assign push        = inflight;

  // A head leaving this cycle frees its slot for the read issued now, giving 1 instr/cycle.
  assign occupancy   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop_now};
  assign room        = occupancy < (CW+1)'(BUF_DEPTH);

  assign would_issue = !reset && (state == RUN) && !halt && room;
  assign err_trip    = would_issue && !pc_ok && !redirect;
  assign im_en       = would_issue && pc_ok;
  assign fetch_err   = (state == ERR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (err_trip) begin
          state_next = ERR;
        end else if (halt) begin
          state_next = HALT;
        end
      end
      HALT: begin
        if (!halt) begin
          state_next = RUN;
        end
      end
      ERR:     state_next = ERR;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      err_pc   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else begin
      if (err_trip) begin
        err_pc <= fetch_pc;
      end
      // Redirect drops the buffered entries, the word being captured now and the read just issued.
      if (redirect) begin
        fetch_pc <= redirect_pc;
        inflight <= 1'b0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        inflight <= im_en;
        if (im_en) begin
          fetch_pc <= fetch_pc + 32'd4;
          tag_pc   <= fetch_pc;
        end
        if (push) begin
          data_q[wr_ptr] <= im_dout;
          pc_q[wr_ptr]   <= tag_pc;
          wr_ptr         <= wr_ptr + 1'b1;
        end
        if (pop_now) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop_now})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef IFU_FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch <= '0;
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (im_en) begin
        perf_fetch <= perf_fetch + 32'd1;
      end
      if (instr_valid && !instr_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
      if (redirect) begin
        perf_flush <= perf_flush + 32'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
